// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: runs one 256-bit cache line transfer as a 4-beat 64-bit memory burst (optional watchdog: ADAPTOR_TIMEOUT_EN)
module line_burst_adaptor #(
    parameter int BURST_W = 64,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       read_i,
    input  logic                       write_i,
    input  logic [31:0]                address_i,
    input  logic [BURST_W*BEATS-1:0]   line_i,
    output logic [BURST_W*BEATS-1:0]   line_o,
    output logic                       resp_o,
    output logic                       error_o,
    output logic [31:0]                address_o,
    output logic                       read_o,
    output logic                       write_o,
    output logic [BURST_W-1:0]         burst_o,
    input  logic [BURST_W-1:0]         burst_i,
    input  logic                       resp_i
);
    localparam int LINE_W = BURST_W * BEATS;
    localparam int CW     = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, next;
    logic [CW-1:0]     cnt;
    logic [LINE_W-1:0] wbuf;
    logic              busy, last, abort;

    assign busy = (state == READ) || (state == WRITE);
    assign last = resp_i && (cnt == CW'(BEATS - 1));

`ifdef ADAPTOR_TIMEOUT_EN
    logic [7:0] wd;
    logic       err;

    assign abort   = busy && !resp_i && (wd == 8'(TIMEOUT - 1));
    assign error_o = err;

    // watchdog restarts on every beat and on entry, flags an abort into DONE
    always_ff @(posedge clk) begin
        wd  <= (rst || !busy || resp_i) ? 8'd0 : wd + 8'd1;
        err <= !rst && abort;
    end
`else
    assign abort   = 1'b0;
    assign error_o = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next;
    end

    // next-state: write wins over read, a burst ends on its last beat or an abort
    always_comb begin
        next = state;
        case (state)
            IDLE:        next = write_i ? WRITE : (read_i ? READ : IDLE);
            READ, WRITE: next = (last || abort) ? DONE : state;
            default:     next = IDLE;
        endcase
    end

    // outputs decoded from state; the write beat is selected by the beat counter
    always_comb begin
        read_o  = state == READ;
        write_o = state == WRITE;
        resp_o  = state == DONE;
        burst_o = (state == WRITE) ? wbuf[cnt*BURST_W +: BURST_W] : '0;
    end

    // request capture, beat counting and fill-line assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            line_o    <= '0;
            wbuf      <= '0;
            address_o <= '0;
        end else begin
            if (state == IDLE && (read_i || write_i))
                address_o <= address_i & ~32'h1f;
            if (state == IDLE && write_i)
                wbuf <= line_i;
            if (busy && resp_i)
                cnt <= cnt + 1'b1;
            else if (state == DONE)
                cnt <= '0;
            if (state == READ && resp_i)
                line_o[cnt*BURST_W +: BURST_W] <= burst_i;
        end
    end
endmodule
